// File: rtl/lector_rtc_pkg.sv
// Shared constants and types for the RTC reader.
//   N_TRANS       transactions per sweep (command write + 11 reads)
//   DIR_TABLA     RTC register addresses, entry 0 feeds datos0
//   CMD_TRANSFER  address of the RTC transfer command register
//   estado_t      bus-cycle state encoding
//   dir_trans()   address used by transaction index t
package rtc_pkg;
  localparam int N_TRANS  = 12;
  localparam int N_REGS   = 11;
  localparam int FASE_DEF = 10;

  localparam logic [7:0] CMD_TRANSFER = 8'hF0;

  // Packed so that DIR_TABLA[0] is 0x21 (seconds) and DIR_TABLA[10] is 0x43.
  localparam logic [N_REGS-1:0][7:0] DIR_TABLA = {
    8'h43, 8'h42, 8'h41,
    8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_DIR    = 3'd1,
    P_PAUSA1 = 3'd2,
    P_DATO   = 3'd3,
    P_PAUSA2 = 3'd4,
    COMMIT   = 3'd5
  } estado_t;

  // t=0 is the transfer command, t=1..11 walk the register table.
  function automatic logic [7:0] dir_trans(input logic [3:0] t);
    if (t == 4'd0)       return CMD_TRANSFER;
    else if (t <= 4'd11) return DIR_TABLA[t - 4'd1];
    else                 return 8'h00;
  endfunction
endpackage

// File: rtl/lector_rtc_if.sv
// RTC bus and display-side handshake bundle.
//   iniciar        sweep request
//   ad_in/ad_out   multiplexed RTC bus, ad_oe = drive enable
//   a_d            0 = address phase, 1 = data phase
//   cs_n/rd_n/wr_n RTC strobes, active low
//   ocupado/listo  sweep in progress / one-cycle commit pulse
//   datos[0..10]   committed BCD bytes
interface lector_rtc_if;
  logic             iniciar;
  logic [7:0]       ad_in;
  logic [7:0]       ad_out;
  logic             ad_oe;
  logic             a_d;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic             ocupado;
  logic             listo;
  logic [10:0][7:0] datos;

  modport master (
    input  iniciar, ad_in,
    output ad_out, ad_oe, a_d, cs_n, rd_n, wr_n, ocupado, listo, datos
  );
  modport slave (
    output iniciar, ad_in,
    input  ad_out, ad_oe, a_d, cs_n, rd_n, wr_n, ocupado, listo, datos
  );
endinterface

// File: rtl/ciclo_bus_rtc.sv
// One RTC bus transaction: address, pause, data, pause, FASE_CICLOS cycles each.
//   go       start (accepted when idle or on the final pause cycle, so
//            transactions chain back to back with no gap)
//   dir      address for this transaction, escribe = write 0x00 instead of read
//   fin      combinational: this is the last cycle of the transaction
//   dato     byte sampled from ad_in on the last cycle of a read data phase
// All bus outputs are registers loaded with the values of the phase being entered.
module ciclo_bus_rtc import rtc_pkg::*; #(
  parameter int FASE_CICLOS = FASE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       escribe,
  input  logic [7:0] dir,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       fin,
  output logic [7:0] dato
);
  estado_t    fase;
  logic [7:0] cnt;
  logic       wr_q;
  logic       ult;

  assign ult = (cnt == 8'(FASE_CICLOS - 1));
  assign fin = (fase == P_PAUSA2) && ult;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fase   <= IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      ad_out <= '0;
      ad_oe  <= 1'b0;
      a_d    <= 1'b0;
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      dato   <= '0;
    end else if (go && (fase == IDLE || fin)) begin
      fase   <= P_DIR;
      cnt    <= '0;
      wr_q   <= escribe;
      a_d    <= 1'b0;
      cs_n   <= 1'b0;
      wr_n   <= 1'b0;
      rd_n   <= 1'b1;
      ad_oe  <= 1'b1;
      ad_out <= dir;
    end else if (fase != IDLE) begin
      if (!ult) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
        case (fase)
          P_DIR: begin
            fase  <= P_PAUSA1;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
          end
          P_PAUSA1: begin
            fase <= P_DATO;
            a_d  <= 1'b1;
            cs_n <= 1'b0;
            if (wr_q) begin
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= 8'h00;
            end else begin
              rd_n <= 1'b0;
            end
          end
          P_DATO: begin
            fase  <= P_PAUSA2;
            cs_n  <= 1'b1;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
            if (!wr_q) dato <= ad_in;
          end
          default: fase <= IDLE;  // end of P_PAUSA2 with nothing chained
        endcase
      end
    end
  end
endmodule

// File: rtl/lector_rtc.sv
// RTC reader: sweeps command + 11 register reads and commits the bytes atomically.
//   clk, reset  clock and asynchronous active-high reset
//   bus         lector_rtc_if.master (request, RTC bus, results)
// Idle means neither sweeping nor in the commit cycle, so a request arriving
// during the listo cycle is dropped rather than queued.
module lector_rtc import rtc_pkg::*; #(
  parameter int FASE_CICLOS = FASE_DEF
) (
  input logic          clk,
  input logic          reset,
  lector_rtc_if.master bus
);
  logic [3:0]              t;
  logic [3:0]              t_sig;
  logic [N_REGS-1:0][7:0]  staging;
  logic [N_REGS-1:0][7:0]  datos;
  logic [N_REGS-1:0][7:0]  cargado;
  logic                    arranca, sigue, go, fin;
  logic [7:0]              dato;
  logic                    ocupado, listo;

  assign arranca = !ocupado && !listo && bus.iniciar;
  assign sigue   = fin && (t < 4'(N_TRANS - 1));
  assign go      = arranca || sigue;
  assign t_sig   = arranca ? 4'd0 : t + 4'd1;

  // The last byte arrives on the same edge as the commit, so it bypasses staging.
  always_comb begin
    cargado         = staging;
    cargado[N_REGS-1] = dato;
  end

  ciclo_bus_rtc #(.FASE_CICLOS(FASE_CICLOS)) u_ciclo (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .escribe (t_sig == 4'd0),
    .dir     (dir_trans(t_sig)),
    .ad_in   (bus.ad_in),
    .ad_out  (bus.ad_out),
    .ad_oe   (bus.ad_oe),
    .a_d     (bus.a_d),
    .cs_n    (bus.cs_n),
    .rd_n    (bus.rd_n),
    .wr_n    (bus.wr_n),
    .fin     (fin),
    .dato    (dato)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t       <= '0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      staging <= '0;
      datos   <= '0;
    end else begin
      listo <= 1'b0;
      if (arranca) begin
        ocupado <= 1'b1;
        t       <= '0;
      end else if (fin) begin
        if (t != 4'd0) staging[t - 4'd1] <= dato;
        if (t < 4'(N_TRANS - 1)) begin
          t <= t + 4'd1;
        end else begin
          t       <= '0;
          ocupado <= 1'b0;
          listo   <= 1'b1;
          datos   <= cargado;
        end
      end
    end
  end

  assign bus.ocupado = ocupado;
  assign bus.listo   = listo;
  assign bus.datos   = datos;
endmodule

// File: tb/tb_lector_rtc.sv
// Bench for lector_rtc: two instances (10- and 2-cycle phases), an RTC bus
// model, and a cycle-indexed expectation model checked on every falling edge.
module tb_lector_rtc;
  localparam int FA = 10;
  localparam int FB = 2;

  typedef struct packed {
    logic [7:0]       ad_out;
    logic             ad_oe, a_d, cs_n, rd_n, wr_n, ocupado, listo;
    logic [10:0][7:0] datos;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  int   cyc = 0, checks = 0, failures = 0;
  int   n_listo_a = 0, n_listo_b = 0;
  bit   chk_on = 1'b0;

  logic [7:0] tab_dir [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                               8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
  logic [7:0] tab_val [11] = '{8'h45, 8'h30, 8'h12, 8'h24, 8'h03, 8'h17,
                               8'h05, 8'h12, 8'h59, 8'h10, 8'h02};

  lector_rtc_if ifa ();
  lector_rtc_if ifb ();

  lector_rtc #(.FASE_CICLOS(FA)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  lector_rtc #(.FASE_CICLOS(FB)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: latches the address phase; instance B's contents shift by one
  // on every transfer command so consecutive sweeps return different bytes.
  logic [7:0] addr_a = 8'h00, addr_b = 8'h00, gen_b = 8'h00;

  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    for (int j = 0; j < 11; j++) if (tab_dir[j] == a) return tab_val[j];
    return 8'hEE;
  endfunction

  assign ifa.ad_in = rtc_val(addr_a);
  assign ifb.ad_in = rtc_val(addr_b) + gen_b;

  always @(posedge clk) begin
    if (!ifa.cs_n && !ifa.a_d && !ifa.wr_n) addr_a <= ifa.ad_out;
    if (!ifb.cs_n && !ifb.a_d && !ifb.wr_n) begin
      addr_b <= ifb.ad_out;
      if (ifb.ad_out == 8'hF0 && addr_b != 8'hF0) gen_b <= gen_b + 8'd1;
    end
  end

  // Expectation model: k = cycles since the accepted request (0 = idle).
  int               k_a = 0, k_b = 0;
  logic [10:0][7:0] exp_a = '0, exp_b = '0;

  function automatic int next_k(input int k, input int f, input logic ini);
    if (k == 0) return ini ? 1 : 0;
    if (k == 48 * f + 1) return 0;
    return k + 1;
  endfunction

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      k_a   <= 0;
      exp_a <= '0;
    end else begin
      k_a <= next_k(k_a, FA, ifa.iniciar);
      if (next_k(k_a, FA, ifa.iniciar) == 48 * FA + 1)
        for (int j = 0; j < 11; j++) exp_a[j] <= tab_val[j];
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      k_b   <= 0;
      exp_b <= '0;
    end else begin
      k_b <= next_k(k_b, FB, ifb.iniciar);
      if (next_k(k_b, FB, ifb.iniciar) == 48 * FB + 1)
        for (int j = 0; j < 11; j++) exp_b[j] <= tab_val[j] + gen_b;
    end
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic cmp(input string d, input obs_t o, input int k, input int f,
                     input logic [10:0][7:0] ed);
    obs_t e;
    bit   swp;
    int   t, p;
    e = '0;
    e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
    e.datos = ed;
    swp = (k >= 1 && k <= 48 * f);
    if (swp) begin
      t = (k - 1) / (4 * f);
      p = ((k - 1) / f) % 4;
      e.ocupado = 1'b1;
      case (p)
        0: begin
          e.cs_n = 1'b0; e.wr_n = 1'b0; e.ad_oe = 1'b1;
          if (t == 0) e.ad_out = 8'hF0;
          else        e.ad_out = tab_dir[t - 1];
        end
        1: e.a_d = 1'b0;
        2: begin
          e.a_d = 1'b1; e.cs_n = 1'b0;
          if (t == 0) begin
            e.wr_n = 1'b0; e.ad_oe = 1'b1; e.ad_out = 8'h00;
          end else begin
            e.rd_n = 1'b0;
          end
        end
        default: e.a_d = 1'b1;
      endcase
    end else if (k == 48 * f + 1) begin
      e.listo = 1'b1;
    end
    chk({d, ".strobes"}, {o.cs_n, o.rd_n, o.wr_n}, {e.cs_n, e.rd_n, e.wr_n});
    chk({d, ".ad_oe"}, o.ad_oe, e.ad_oe);
    chk({d, ".ocupado"}, o.ocupado, e.ocupado);
    chk({d, ".listo"}, o.listo, e.listo);
    chk({d, ".datos"}, o.datos, e.datos);
    chk({d, ".rd_wr_excl"}, o.rd_n | o.wr_n, 1'b1);
    if (e.ad_oe) chk({d, ".ad_out"}, o.ad_out, e.ad_out);
    if (swp)     chk({d, ".a_d"}, o.a_d, e.a_d);
  endtask

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.ad_out, ifa.ad_oe, ifa.a_d, ifa.cs_n, ifa.rd_n, ifa.wr_n,
                  ifa.ocupado, ifa.listo, ifa.datos};
  assign obs_b = {ifb.ad_out, ifb.ad_oe, ifb.a_d, ifb.cs_n, ifb.rd_n, ifb.wr_n,
                  ifb.ocupado, ifb.listo, ifb.datos};

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a", obs_a, k_a, FA, exp_a);
      cmp("b", obs_b, k_b, FB, exp_b);
      if (ifa.listo) n_listo_a++;
      if (ifb.listo) n_listo_b++;
    end
  end

  // Returns 1 time unit after edge number n.
  task automatic at(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int ea, e2, e3, eb, eb2;

  initial begin
    ifa.iniciar = 1'b0;
    ifb.iniciar = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    at(2);
    rst_a = 1'b0; rst_b = 1'b0;
    chk_on = 1'b1;

    // Reset asserted during cycle 5 for 3 cycles.
    at(4);
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    chk("lit.rst_strobes", {ifa.cs_n, ifa.rd_n, ifa.wr_n}, 3'b111);
    chk("lit.rst_ad_out", ifa.ad_out, 8'h00);
    chk("lit.rst_ocupado", ifa.ocupado, 1'b0);
    chk("lit.rst_datos_b", ifb.datos, 88'h0);
    at(7);
    rst_a = 1'b0; rst_b = 1'b0;

    // Full sweep on A with busy request at +100 and commit-cycle request.
    ea = 20;
    at(ea - 1); ifa.iniciar = 1'b1;
    at(ea);     ifa.iniciar = 1'b0;
    chk("lit.a_start_ad_out", ifa.ad_out, 8'hF0);
    at(ea + 99); ifa.iniciar = 1'b1;
    at(ea + 100); ifa.iniciar = 1'b0;
    at(ea + 479);
    chk("lit.a_ocupado_480", ifa.ocupado, 1'b1);
    at(ea + 480);
    chk("lit.a_listo_481", ifa.listo, 1'b1);
    chk("lit.a_datos0", ifa.datos[0], 8'h45);
    chk("lit.a_datos10", ifa.datos[10], 8'h02);
    ifa.iniciar = 1'b1;              // sampled at ea+481 (COMMIT) and ea+482
    at(ea + 481);
    chk("lit.a_listo_482", ifa.listo, 1'b0);
    chk("lit.a_idle_482", ifa.ocupado, 1'b0);
    at(ea + 482);
    ifa.iniciar = 1'b0;
    chk("lit.a_restart_483", ifa.ocupado, 1'b1);
    chk("lit.a_one_listo", n_listo_a, 1);

    // Reset in the middle of the second sweep.
    e2 = ea + 482;
    at(e2 + 249);
    rst_a = 1'b1;
    #1;
    chk("lit.a_mid_rst_datos", ifa.datos, 88'h0);
    chk("lit.a_mid_rst_ocupado", ifa.ocupado, 1'b0);
    at(e2 + 252);
    rst_a = 1'b0;
    at(e2 + 260);
    chk("lit.a_stays_idle", ifa.ocupado, 1'b0);
    e3 = e2 + 262;
    at(e3 - 1); ifa.iniciar = 1'b1;
    at(e3);     ifa.iniciar = 1'b0;
    at(e3 + 480);
    chk("lit.a3_listo", ifa.listo, 1'b1);
    chk("lit.a3_datos5", ifa.datos[5], 8'h17);
    at(e3 + 482);
    chk("lit.a_two_listo", n_listo_a, 2);

    // Short phases on B; contents shift by one per sweep.
    eb = e3 + 490;
    at(eb - 1); ifb.iniciar = 1'b1;
    at(eb);     ifb.iniciar = 1'b0;
    at(eb + 95);
    chk("lit.b_ocupado_96", ifb.ocupado, 1'b1);
    at(eb + 96);
    chk("lit.b_listo_97", ifb.listo, 1'b1);
    chk("lit.b_datos0", ifb.datos[0], 8'h46);
    chk("lit.b_datos10", ifb.datos[10], 8'h03);
    eb2 = eb + 100;
    at(eb2 - 1); ifb.iniciar = 1'b1;
    at(eb2);     ifb.iniciar = 1'b0;
    at(eb2 + 95);
    chk("lit.b2_old_datos0", ifb.datos[0], 8'h46);
    at(eb2 + 96);
    chk("lit.b2_new_datos0", ifb.datos[0], 8'h47);
    chk("lit.b2_new_datos8", ifb.datos[8], 8'h5B);
    at(eb2 + 100);
    chk("lit.b_two_listo", n_listo_b, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lector_rtc.md
# lector_rtc

Bus master that reads the time, date and timer registers of the external RTC over its multiplexed address/data bus and supplies the eleven BCD bytes consumed by the VGA display path as datos0–datos10. On each start request it:
- issues the RTC transfer command;
- sweeps the eleven registers;
- commits all bytes atomically with a one-cycle `listo` pulse, so the display never sees a half-updated set.

## Interface
- FASE_CICLOS, 10, clock cycles per bus phase; legal range 2–255.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  sweep request; accepted only in IDLE.
- ad_in  in  8  RTC bus input; sampled during read data phases.
- ad_out  out  8  RTC bus drive value.
- ad_oe  out  1  tristate enable for ad_out; 1 = drive.
- a_d  out  1  RTC A/D select; 0 = address phase, 1 = data phase.
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low.
- ocupado  out  1  sweep in progress.
- listo  out  1  one-cycle pulse when new data is committed.
- datos0..datos10  out  8 each  committed BCD bytes:
  - datos0–datos7: seg, min, hora, fecha, mes, año, día semana, número semana;
  - datos8–datos10: timer seg, min, hora.

## Operation
- States: IDLE, P_DIR, P_PAUSA1, P_DATO, P_PAUSA2, COMMIT.
- Transaction index t runs 0..11:
  - t=0 is a write of 0x00 to address 0xF0 (transfer command);
  - t=1..11 are reads of address table entries 0..10: 0x21–0x28, then 0x41–0x43.
- P_DIR: a_d=0, cs_n=0, wr_n=0, ad_oe=1, ad_out=address.
- P_PAUSA1 / P_PAUSA2: cs_n=rd_n=wr_n=1, ad_oe=0. a_d holds its previous value.
- P_DATO, write transaction: a_d=1, cs_n=0, wr_n=0, ad_oe=1, ad_out=0x00.
- P_DATO, read transaction: a_d=1, cs_n=0, rd_n=0, ad_oe=0. ad_in is captured into staging[t-1] on the last cycle of the phase.
- Every phase lasts exactly FASE_CICLOS cycles. A phase counter counts 0..FASE_CICLOS-1 and wraps to 0 on each phase change.
- Transitions:
  - P_PAUSA2 → P_DIR with t+1 if t<11;
  - P_PAUSA2 → COMMIT if t=11;
  - COMMIT → IDLE after one cycle.
- COMMIT loads all eleven datos registers from staging in one edge and raises listo.
- In every state other than P_DIR and write-P_DATO: ad_oe=0. In IDLE: all strobes high.
- rd_n and wr_n are never low together. cs_n is never low outside P_DIR/P_DATO.
- iniciar while ocupado=1 is ignored; no queuing.
- Staging contents outside COMMIT are never visible on datos.
- No validation of BCD content: bytes pass through unchanged.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset values:
  - cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0x00;
  - ocupado=0, listo=0;
  - all datos=0x00, staging=0;
  - state IDLE, t=0, phase counter 0.
- Sweep timing, with iniciar=1 sampled at edge E in IDLE:
  - cycle E+1: ocupado=1 and the P_DIR outputs of t=0 are present;
  - the sweep occupies 48·FASE_CICLOS cycles (E+1 .. E+48F);
  - cycle E+48F+1 is COMMIT: datos show new values, listo=1, ocupado=0;
  - cycle E+48F+2: listo=0, state IDLE.
- iniciar=1 during the COMMIT cycle is ignored. The earliest accepted restart is at edge E+48F+2.
- Read capture for t: the edge that ends P_DATO. rd_n has then been low for FASE_CICLOS cycles.
- Reset asserted mid-sweep:
  - outputs return to reset values asynchronously;
  - datos clear to 0x00;
  - no listo pulse;
  - after release, the block sits in IDLE until a new iniciar.

## Structure
- Shared package `rtc_pkg` holds:
  - the 11-entry register address table;
  - CMD_TRANSFER=0xF0;
  - N_TRANS=12;
  - the state enum;
  - the FASE_CICLOS default.
- One sub-module, `ciclo_bus_rtc`:
  - executes one transaction (phase counter plus strobe generation) given address, write flag and a go pulse;
  - returns a done pulse and the captured byte.
- `lector_rtc` keeps the transaction index, staging array and commit logic.

## Test plan
- Reset: assert reset at cycle 5 for 3 cycles → all strobes 1, ad_oe=0, ocupado=0, listo=0, datos0..10=0x00.
- Full sweep, FASE_CICLOS=10, with an RTC model returning 0x45,0x30,0x12,0x24,0x03,0x17,0x05,0x12,0x59,0x10,0x02 for 0x21..0x43; iniciar at edge 0 → ocupado cycles 1–480, listo=1 only at cycle 481 with datos0=0x45 … datos10=0x02, listo=0 at 482.
- Strobe check, same run → t=0 address phase has ad_out=0xF0, ad_oe=1, wr_n=0 for 10 cycles; write data phase has ad_out=0x00; rd_n never low together with wr_n; ad_oe=0 throughout every read P_DATO.
- Busy and COMMIT requests: iniciar pulses at cycles 100 and 481 → both ignored, exactly one listo; iniciar at 482 → new sweep, ocupado=1 at 483.
- Reset mid-sweep: reset at cycle 250 (after datos committed by a previous sweep) → datos=0x00 immediately, no listo; new iniciar → a full 480-cycle sweep then correct values.
- FASE_CICLOS=2: sweep of 96 cycles, listo at cycle 97, values correct; model returns a different byte each sweep → datos change only at the COMMIT edge.
